// File: rtl/decoder_pkg.sv
// Shared types and widths for the pulse-stretching 3-to-8 decoder.
package decoder_pkg;

   localparam int unsigned CodeW = 3;
   localparam int unsigned OutW  = 8;
   localparam int unsigned CntW  = 8;

   typedef enum logic [1:0] {
      StIdle,
      StHold,
      StGap
   } state_e;

endpackage

// File: rtl/dec3to8.sv
// Pure combinational binary-to-one-hot decode.
module dec3to8
   import decoder_pkg::*;
(
   input  logic [CodeW-1:0] in,
   output logic [OutW-1:0]  out
);

   always_comb begin
      out     = '0;
      out[in] = 1'b1;
   end

endmodule

// File: rtl/decoder_pulse.sv
// Decodes a 3-bit code into a one-hot pulse held HOLD cycles, followed by GAP idle cycles.
// Optional macro DECODER_PULSE_ACTLOW_EN drives out active-low (idle 8'hFF).
module decoder_pulse
   import decoder_pkg::*;
#(
   parameter int unsigned HOLD = 4,
   parameter int unsigned GAP  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [CodeW-1:0] in,
   output logic             in_ready,
   output logic [OutW-1:0]  out,
   output logic             out_valid,
   output logic             busy
);

   localparam logic [CntW-1:0] HoldLd = CntW'(HOLD - 1);
   localparam logic [CntW-1:0] GapLd  = (GAP > 0) ? CntW'(GAP - 1) : '0;
   localparam logic            GapEn  = (GAP > 0);

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [OutW-1:0]   out_q, out_d;
   logic              pend_v_q, pend_v_d;
   logic [CodeW-1:0]  pend_code_q, pend_code_d;
   logic              load;
   logic              xfer;
   logic [OutW-1:0]   dec_out;

   dec3to8 u_dec (
      .in  (pend_code_q),
      .out (dec_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         out_q       <= '0;
         pend_v_q    <= 1'b0;
         pend_code_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         pend_v_q    <= pend_v_d;
         pend_code_q <= pend_code_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      load    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (pend_v_q) load = 1'b1;
         end
         StHold: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (GapEn) begin
               state_d = StGap;
               cnt_d   = GapLd;
               out_d   = '0;
            end else if (pend_v_q) begin
               load = 1'b1;  // back-to-back with no zero cycle
            end else begin
               state_d = StIdle;
               out_d   = '0;
            end
         end
         StGap: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (pend_v_q) begin
               load = 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (load) begin
         state_d = StHold;
         cnt_d   = HoldLd;
         out_d   = dec_out;
      end
   end

   // A refill in the same cycle as a consume keeps pend_v set with the new code.
   always_comb begin
      xfer        = in_valid && (!pend_v_q || load);
      pend_v_d    = pend_v_q;
      pend_code_d = pend_code_q;
      if (xfer) begin
         pend_v_d    = 1'b1;
         pend_code_d = in;
      end else if (load) begin
         pend_v_d = 1'b0;
      end
   end

   always_comb begin
      in_ready  = !pend_v_q || load;
      out_valid = (state_q == StHold);
      busy      = (state_q != StIdle) || pend_v_q;
`ifdef DECODER_PULSE_ACTLOW_EN
      out       = ~out_q;
`else
      out       = out_q;
`endif
   end

endmodule

// File: tb/tb_decoder_pulse.sv
// Scoreboard bench for decoder_pulse: default instance (HOLD=4, GAP=1) and a GAP=0 instance.
module tb_decoder_pulse;

   localparam int HoldA = 4;
   localparam int GapA  = 1;
   localparam int HoldB = 4;
   localparam int GapB  = 0;
`ifdef DECODER_PULSE_ACTLOW_EN
   localparam logic [7:0] IdleOut = 8'hFF;
`else
   localparam logic [7:0] IdleOut = 8'h00;
`endif

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       vld_a = 1'b0;
   logic       vld_b = 1'b0;
   logic [2:0] in_a  = 3'd0;
   logic [2:0] in_b  = 3'd0;
   logic       rdy_a, rdy_b, ov_a, ov_b, busy_a, busy_b;
   logic [7:0] out_a, out_b;

   int         checks = 0;
   int         errors = 0;
   logic [2:0] exp_q[$];

   always #5 clk = ~clk;

   decoder_pulse #(.HOLD(HoldA), .GAP(GapA)) u_dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (vld_a),
      .in        (in_a),
      .in_ready  (rdy_a),
      .out       (out_a),
      .out_valid (ov_a),
      .busy      (busy_a)
   );

   decoder_pulse #(.HOLD(HoldB), .GAP(GapB)) u_dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (vld_b),
      .in        (in_b),
      .in_ready  (rdy_b),
      .out       (out_b),
      .out_valid (ov_b),
      .busy      (busy_b)
   );

   function automatic logic [7:0] onehot(input logic [2:0] c);
      logic [7:0] r;
      r    = '0;
      r[c] = 1'b1;
      return r;
   endfunction

   // Called at a negedge; returns at the negedge following the transfer edge.
   task automatic send(input bit sel, input logic [2:0] c, output bit stalled);
      bit done;
      done    = 1'b0;
      stalled = 1'b0;
      if (sel) begin vld_b = 1'b1; in_b = c; end
      else     begin vld_a = 1'b1; in_a = c; end
      for (int n = 0; n < 40 && !done; n++) begin
         if (sel ? rdy_b : rdy_a) begin
            exp_q.push_back(c);
            @(negedge clk);
            done = 1'b1;
         end else begin
            stalled = 1'b1;
            @(negedge clk);
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL send_timeout code=%0d got_ready=0 required_ready=1", c);
      end
   endtask

   task automatic monitor(input bit sel, input int ncyc, input int hold, input int gap);
      logic [7:0] o, last;
      logic       v;
      logic [2:0] c;
      int         seg_len, zero_len;
      bit         have_seg;
      last = '0; seg_len = 0; zero_len = 0; have_seg = 1'b0;
      repeat (ncyc) begin
         @(negedge clk);
         o = (sel ? out_b : out_a) ^ IdleOut;
         v = sel ? ov_b : ov_a;
         checks++;
         if (v !== (o != 8'h00)) begin
            errors++;
            $display("FAIL out_valid got=%b out=%h required=%b", v, o, (o != 8'h00));
         end
         checks++;
         if ($countones(o) > 1) begin
            errors++;
            $display("FAIL onehot got=%h required_at_most_one_bit", o);
         end
         if (o != 8'h00) begin
            if (o != last) begin
               if (last != 8'h00) begin
                  checks++;
                  if (seg_len != hold) begin
                     errors++;
                     $display("FAIL hold_len got=%0d required=%0d", seg_len, hold);
                  end
               end else if (have_seg) begin
                  checks++;
                  if (zero_len != gap) begin
                     errors++;
                     $display("FAIL gap_len got=%0d required=%0d", zero_len, gap);
                  end
               end
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_code got=%h required=none", o);
               end else begin
                  c = exp_q.pop_front();
                  if (o !== onehot(c)) begin
                     errors++;
                     $display("FAIL code got=%h required=%h", o, onehot(c));
                  end
               end
               seg_len  = 0;
               have_seg = 1'b1;
            end
            seg_len++;
            zero_len = 0;
         end else begin
            if (last != 8'h00) begin
               checks++;
               if (seg_len != hold) begin
                  errors++;
                  $display("FAIL hold_len got=%0d required=%0d", seg_len, hold);
               end
            end
            zero_len++;
         end
         last = o;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL lost_codes got_left=%0d required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_idle(input string name);
      checks++;
      if (out_a !== IdleOut || ov_a !== 1'b0 || busy_a !== 1'b0 || rdy_a !== 1'b1) begin
         errors++;
         $display("FAIL %s_a got out=%h ov=%b busy=%b rdy=%b required out=%h ov=0 busy=0 rdy=1",
                  name, out_a, ov_a, busy_a, rdy_a, IdleOut);
      end
      checks++;
      if (out_b !== IdleOut || ov_b !== 1'b0 || busy_b !== 1'b0 || rdy_b !== 1'b1) begin
         errors++;
         $display("FAIL %s_b got out=%h ov=%b busy=%b rdy=%b required out=%h ov=0 busy=0 rdy=1",
                  name, out_b, ov_b, busy_b, rdy_b, IdleOut);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      check_idle("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("post_reset");
   endtask

   // Cycle-exact latency, hold length and busy release for a lone code 3.
   task automatic test_single();
      logic [7:0] exp_out;
      bit         exp_on;
      vld_a = 1'b1;
      in_a  = 3'd3;
      checks++;
      if (rdy_a !== 1'b1) begin
         errors++;
         $display("FAIL single_ready got=%b required=1", rdy_a);
      end
      @(posedge clk);
      #1;
      vld_a = 1'b0;
      in_a  = 3'd0;
      @(negedge clk);
      checks++;
      if (out_a !== IdleOut || busy_a !== 1'b1) begin
         errors++;
         $display("FAIL single_k got out=%h busy=%b required out=%h busy=1", out_a, busy_a, IdleOut);
      end
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         exp_on  = (i <= HoldA);
         exp_out = exp_on ? (onehot(3'd3) ^ IdleOut) : IdleOut;
         checks++;
         if (out_a !== exp_out || ov_a !== exp_on || busy_a !== (i <= HoldA + GapA)) begin
            errors++;
            $display("FAIL single_k+%0d got out=%h ov=%b busy=%b required out=%h ov=%b busy=%b",
                     i, out_a, ov_a, busy_a, exp_out, exp_on, (i <= HoldA + GapA));
         end
      end
   endtask

   task automatic test_back_to_back();
      bit s0, s1, s2;
      fork
         monitor(1'b0, 45, HoldA, GapA);
         begin
            send(1'b0, 3'd0, s0);
            send(1'b0, 3'd7, s1);
            send(1'b0, 3'd2, s2);
            vld_a = 1'b0;
         end
      join
      checks++;
      if (!(s1 || s2)) begin
         errors++;
         $display("FAIL ready_drop got_stall=0 required_stall=1");
      end
   endtask

   task automatic test_gap0();
      bit s;
      fork
         monitor(1'b1, 30, HoldB, GapB);
         begin
            send(1'b1, 3'd5, s);
            send(1'b1, 3'd6, s);
            vld_b = 1'b0;
         end
      join
   endtask

   task automatic test_ignore();
      bit s;
      fork
         monitor(1'b0, 40, HoldA, GapA);
         begin
            send(1'b0, 3'd4, s);
            send(1'b0, 3'd5, s);
            vld_a = 1'b1;
            in_a  = 3'd1;
            for (int i = 0; i < 4; i++) begin
               if (i > 0) @(negedge clk);
               checks++;
               if (rdy_a !== 1'b0) begin
                  errors++;
                  $display("FAIL ignore_ready step=%0d got=%b required=0", i, rdy_a);
               end
            end
            vld_a = 1'b0;
            in_a  = 3'd0;
         end
      join
   endtask

   task automatic test_reset_mid();
      bit s;
      send(1'b0, 3'd2, s);
      send(1'b0, 3'd6, s);
      vld_a = 1'b0;
      checks++;
      if (ov_a !== 1'b1 || busy_a !== 1'b1 || rdy_a !== 1'b0) begin
         errors++;
         $display("FAIL mid_hold got ov=%b busy=%b rdy=%b required ov=1 busy=1 rdy=0",
                  ov_a, busy_a, rdy_a);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("mid_reset");
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      monitor(1'b0, 15, HoldA, GapA);
      fork
         monitor(1'b0, 15, HoldA, GapA);
         begin
            send(1'b0, 3'd1, s);
            vld_a = 1'b0;
         end
      join
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_gap0();
      test_ignore();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decoder_pulse.md
DECODER_PULSE -- requirements
Module: decoder_pulse

Interface
REQ-001 Parameter HOLD, default 4: cycles each one-hot output stays asserted; legal range 1..255.
REQ-002 Parameter GAP, default 1: all-zero cycles inserted after each hold; legal range 0..255.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, as ports clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  in carries a code to decode.
REQ-007 in  input  3  binary code 0..7.
REQ-008 in_ready  output  1  block accepts in this cycle.
REQ-009 out  output  8  one-hot decode of current code; bit n set for code n.
REQ-010 out_valid  output  1  high exactly while out is non-zero (HOLD state).
REQ-011 busy  output  1  high whenever state is not IDLE or the pending register is full.

Function
REQ-012 Handshake: a transfer occurs on a rising edge where in_valid && in_ready; in SHALL be captured into a 1-entry pending register (pend_code, pend_v).
REQ-013 in_ready = !pend_v || load, where load is the cycle the FSM consumes pending; a same-cycle consume and refill SHALL not lose or duplicate a code.
REQ-014 in_valid without in_ready SHALL be ignored; in SHALL not need to be held stable after a transfer.
REQ-015 FSM states: IDLE, HOLD, GAP; counter cnt width 8.
REQ-016 IDLE: out=0; if pend_v, load: out <= 1<<pend_code, cnt <= HOLD-1, pend_v cleared (unless refilled), go HOLD.
REQ-017 HOLD: out held; cnt decrements each cycle; at cnt==0: if GAP>0 go GAP with cnt <= GAP-1 and out <= 0; else if pend_v load directly (back-to-back, no zero cycle); else go IDLE with out <= 0.
REQ-018 GAP: out=0; cnt decrements; at cnt==0: if pend_v load and go HOLD, else go IDLE.
REQ-019 Latency: transfer at edge k with block IDLE and pending empty -> out non-zero from edge k+1 for exactly HOLD cycles.
REQ-020 Sustained throughput SHALL be one code per HOLD+GAP cycles.
REQ-021 out SHALL never have more than one bit set; out_valid == (out != 0) in every cycle.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, cnt 0, pend_v 0, out 8'h00, out_valid 0, busy 0, in_ready 1.
REQ-023 Reset asserted mid-HOLD or mid-GAP SHALL discard the active and pending codes; first transfer after release behaves per REQ-019.

Configuration
REQ-024 Macro DECODER_PULSE_ACTLOW_EN: when defined, out SHALL be driven bitwise-inverted (active-low, idle value 8'hFF, reset value 8'hFF); when undefined, out is active-high per REQ-009 (idle/reset 8'h00). out_valid polarity unchanged in both builds.

Structure
REQ-025 State encoding typedef (IDLE/HOLD/GAP) and code width constant 3 / output width 8 SHALL live in shared package decoder_pkg.
REQ-026 The pure combinational 3-to-8 decode SHALL be sub-module dec3to8 (in[2:0] -> one-hot out[7:0]); all sequencing stays in decoder_pulse.

Verification
REQ-027 Reset then single transfer in=3 (HOLD=4, GAP=1) -> out=8'h08 for cycles k+1..k+4, 8'h00 at k+5, out_valid matches, busy low from k+6.
REQ-028 Back-to-back stream 0,7,2 with in_valid held high -> outputs 8'h01,8'h80,8'h04 each 4 cycles, separated by 1 zero cycle; in_ready drops while pending full; no code lost or repeated.
REQ-029 GAP=0 with codes 5 then 6 -> out 8'h20 for 4 cycles immediately followed by 8'h40 for 4 cycles, no zero cycle.
REQ-030 rst_n pulsed low mid-HOLD with a code pending -> out=8'h00, pend_v=0 immediately; pending code never appears after release.
REQ-031 in_valid=1 while in_ready=0 with in=1 -> code 1 not captured; only codes transferred with in_ready=1 appear.
REQ-032 Build with DECODER_PULSE_ACTLOW_EN, in=4 -> out=8'hFF idle/reset, 8'hEF during HOLD.
